ssled_mux: RTL

- Parametrised successor to the fixed 4-digit score display driver.
- Takes a binary value through a load/busy handshake and converts it to BCD with a sequential double-dabble engine, one bit per cycle.
- Time-multiplexes N active-low common-anode digits from an internal refresh divider on the system clock.
- Adds leading-zero blanking, an overflow indication, and blink mode; sits between game/score logic and the board's seven-segment pins.

---
 rtl/ssled_pkg.sv | 34 +++
 rtl/ssled_bcd_seq.sv | 66 ++++++
 rtl/ssled_mux.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ssled_pkg.sv
// rtl/ssled_pkg.sv - shared glyphs and width helpers for the seven-segment mux
package ssled_pkg;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  // Counter width for a modulus n; at least one bit so degenerate moduli stay legal
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of the packed BCD display word
  function automatic int bcd_w(input int digits);
    return 4 * digits;
  endfunction

  // Active-low {g..a} glyph for one BCD nibble; non-decimal nibbles stay dark
  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_OFF;
    endcase
  endfunction

endpackage

// File: rtl/ssled_bcd_seq.sv
// rtl/ssled_bcd_seq.sv - iterative double-dabble converter, one input bit per cycle
module ssled_bcd_seq
  import ssled_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [BIN_W-1:0]            in_bin,
  input  logic                        load,
  output logic                        busy,
  output logic                        done,
  output logic [bcd_w(NUM_DIGITS)-1:0] bcd_out,
  output logic                        carry_out
);

  localparam int BCD_W = bcd_w(NUM_DIGITS);
  localparam int CW    = cnt_w(BIN_W);
  localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] work_q;
  logic [BCD_W-1:0] adj;
  logic             cy_q;
  logic [CW-1:0]    cnt;

  // Add-3 correction on every nibble before the shift; nibbles never exceed 12 so no cross-nibble carry
  always_comb begin
    adj = work_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (work_q[i*4 +: 4] > 4'd4) adj[i*4 +: 4] = work_q[i*4 +: 4] + 4'd3;
    end
  end

  // Result of the current step; the top latches it on the final busy cycle so display and ovf move together
  assign bcd_out   = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
  assign carry_out = cy_q | adj[BCD_W-1];
  assign done      = busy && (cnt == LAST);

  // Capture on an idle load, then shift one binary bit per cycle for BIN_W cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      work_q <= '0;
      cy_q   <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (!busy) begin
      if (load) begin
        bin_q  <= in_bin;
        work_q <= '0;
        cy_q   <= 1'b0;
        cnt    <= '0;
        busy   <= 1'b1;
      end
    end else begin
      work_q <= bcd_out;
      cy_q   <= carry_out;
      bin_q  <= {bin_q[BIN_W-2:0], 1'b0};
      cnt    <= cnt + 1'b1;
      if (cnt == LAST) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/ssled_mux.sv
// rtl/ssled_mux.sv - multiplexed seven-segment score display with blanking, overflow and blink
module ssled_mux
  import ssled_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int BIN_W        = 16,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BIN_W-1:0]      in_score,
  input  logic                  load,
  output logic                  busy,
  input  logic                  blank_lz,
  input  logic                  blink_en,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  ovf
);

  localparam int BCD_W = bcd_w(NUM_DIGITS);
  localparam int RW    = cnt_w(REFRESH_DIV);
  localparam int IW    = cnt_w(NUM_DIGITS);
  localparam int BW    = cnt_w(BLINK_FRAMES);
  localparam logic [RW-1:0] RLAST = RW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] ILAST = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLAST = BW'(BLINK_FRAMES - 1);

  logic             conv_done;
  logic             conv_cy;
  logic [BCD_W-1:0] conv_bcd;
  logic [BCD_W-1:0] disp_q;
  logic [RW-1:0]    rcnt;
  logic [IW-1:0]    idx;
  logic [BW-1:0]    bcnt;
  logic             phase_q;
  logic             frame_wrap;
  logic             show;
  logic [3:0]       cur_nib;

  ssled_bcd_seq #(
    .NUM_DIGITS(NUM_DIGITS),
    .BIN_W     (BIN_W)
  ) u_bcd (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_bin   (in_score),
    .load     (load),
    .busy     (busy),
    .done     (conv_done),
    .bcd_out  (conv_bcd),
    .carry_out(conv_cy)
  );

  // Display word and overflow change only when a conversion finishes, so the old value stays up meanwhile
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q <= '0;
      ovf    <= 1'b0;
    end else if (conv_done) begin
      disp_q <= conv_bcd;
      ovf    <= conv_cy;
    end
  end

  // Refresh divider and digit index; the index advances on the divider's terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt <= '0;
      idx  <= '0;
    end else if (rcnt == RLAST) begin
      rcnt <= '0;
      idx  <= (idx == ILAST) ? '0 : idx + 1'b1;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  assign frame_wrap = (rcnt == RLAST) && (idx == ILAST);

  // Blink phase toggles every BLINK_FRAMES completed frames; disabling blink resets to the on phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt    <= '0;
      phase_q <= 1'b1;
    end else if (!blink_en) begin
      bcnt    <= '0;
      phase_q <= 1'b1;
    end else if (frame_wrap) begin
      if (bcnt == BLAST) begin
        bcnt    <= '0;
        phase_q <= ~phase_q;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end

  // Slot visibility: dead-time cycle, blink off phase, and leading-zero blanking (suppressed on overflow)
  always_comb begin
    cur_nib = disp_q[{idx, 2'b00} +: 4];
    show    = (rcnt != '0) && (phase_q || !blink_en);
    if (blank_lz && !ovf && (idx != '0) && ((disp_q >> {idx, 2'b00}) == '0)) show = 1'b0;
  end

  // Registered pin drive; dark slots also drive segments off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_OFF;
      an  <= '1;
    end else if (show) begin
      an  <= ~(NUM_DIGITS'(1) << idx);
      seg <= ovf ? SEG_DASH : digit_glyph(cur_nib);
    end else begin
      an  <= '1;
      seg <= SEG_OFF;
    end
  end

endmodule
